flag_hazard_ctrl: RTL

- Owns the architectural NZCV status register and schedules conditional instructions in the ID stage against in-flight flag-setting instructions.
- Counts S-bit instructions issued but not yet written back from EX. Stalls ID while a conditional instruction would read stale flags, or when the pending tracker is full.
- Produces the condition-pass decision for the ID instruction from committed flags. Sits between ID, EX and the hazard/stall network.

---
 rtl/arm_cond_pkg.sv | 36 +++
 rtl/cond_eval.sv | 38 +++
 rtl/flag_hazard_ctrl.sv | 79 +++++++
 3 files changed

// File: rtl/arm_cond_pkg.sv
// rtl/arm_cond_pkg.sv - ARM condition-code and NZCV flag definitions shared across pipeline stages
package arm_cond_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } pend_state_e;

  // AL and NV never depend on flags, so they never wait on in-flight writers.
  function automatic logic is_conditional(input logic [3:0] cond);
    return !((cond == COND_AL) || (cond == COND_NV));
  endfunction

endpackage

// File: rtl/cond_eval.sv
// rtl/cond_eval.sv - combinational ARM condition-code evaluation against NZCV
module cond_eval
  import arm_cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;

  assign n = nzcv[FLAG_N];
  assign z = nzcv[FLAG_Z];
  assign c = nzcv[FLAG_C];
  assign v = nzcv[FLAG_V];

  always_comb begin
    pass = 1'b1;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      default: pass = 1'b1;
    endcase
  end

endmodule

// File: rtl/flag_hazard_ctrl.sv
// rtl/flag_hazard_ctrl.sv - NZCV status register with in-flight flag-writer tracking and ID stall
module flag_hazard_ctrl
  import arm_cond_pkg::*;
#(
  parameter int         MAX_PEND  = 3,
  parameter logic [3:0] RST_FLAGS = 4'b0000,
  localparam int        CNT_W     = $clog2(MAX_PEND + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [3:0]       id_cond,
  input  logic             id_set_flags,
  input  logic             freeze,
  input  logic             flush,
  input  logic             flags_wr_en,
  input  logic [3:0]       flags_in,
  output logic [3:0]       status_nzcv,
  output logic             id_stall,
  output logic             cond_pass,
  output logic [CNT_W-1:0] pending_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PEND);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  pend_state_e      state, state_next;
  logic [CNT_W-1:0] cnt_next;
  logic             conditional;
  logic             issue_s;

  assign conditional = is_conditional(id_cond);

  // BUSY is exactly pending_cnt != 0, so it doubles as the read-after-write hazard flag.
  assign id_stall = id_valid & ((conditional & (state == ST_BUSY)) |
                                (id_set_flags & (pending_cnt == CNT_MAX)));

  assign issue_s = id_valid & id_set_flags & ~id_stall & ~freeze & ~flush;

  always_comb begin
    cnt_next = pending_cnt;
    if (flush) begin
      cnt_next = '0;
    end else if (issue_s && !flags_wr_en) begin
      cnt_next = pending_cnt + CNT_ONE;
    end else if (!issue_s && flags_wr_en && (pending_cnt != '0)) begin
      cnt_next = pending_cnt - CNT_ONE;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (issue_s && !flags_wr_en && !flush) state_next = ST_BUSY;
      ST_BUSY: if (cnt_next == '0) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // A flag write in a flush cycle belongs to an older instruction and still commits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_nzcv <= RST_FLAGS;
      pending_cnt <= '0;
      state       <= ST_IDLE;
    end else begin
      if (flags_wr_en) status_nzcv <= flags_in;
      pending_cnt <= cnt_next;
      state       <= state_next;
    end
  end

  cond_eval u_cond_eval (
    .cond (id_cond),
    .nzcv (status_nzcv),
    .pass (cond_pass)
  );

endmodule
